// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency reads and
// buffers returned words in a small shift FIFO whose slot 0 drives decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;
    logic        inflight_q, inflight_d;
    logic        inflight_epoch_q, inflight_epoch_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic [31:0] fifo_instr_q [FIFO_DEPTH];
    logic [31:0] fifo_instr_d [FIFO_DEPTH];
    logic [31:0] fifo_pc_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_d [FIFO_DEPTH];

    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic [CW:0]   occ_s;
    logic [CW-1:0] wr_idx_s;
    logic          unused_tgt_bits_s;

    assign unused_tgt_bits_s = ^redirect_target[1:0];

    // Credit rule: a read may only issue if its response is guaranteed a slot.
    assign pop_s   = valid_q & instr_ready;
    assign occ_s   = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop_s);
    assign issue_s = (state_q == ST_RUN) & ~redirect & (occ_s < (CW+1)'(FIFO_DEPTH));
    assign push_s  = inflight_q & (inflight_epoch_q == epoch_q) & ~redirect;

    assign imem_req    = issue_s;
    assign imem_addr   = issue_s ? pc_q : 32'h0000_0000;
    assign instr       = fifo_instr_q[0];
    assign instr_pc    = fifo_pc_q[0];
    assign instr_valid = valid_q;

    // Next-state: FSM, PC/epoch update, in-flight tracking and FIFO shift/push.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        epoch_d          = epoch_q;
        inflight_d       = issue_s;
        inflight_epoch_d = epoch_q;
        inflight_pc_d    = inflight_pc_q;
        count_d          = count_q;
        wr_idx_s         = count_q;
        fifo_instr_d     = fifo_instr_q;
        fifo_pc_d        = fifo_pc_q;

        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        if (redirect) begin
            pc_d    = {redirect_target[31:2], 2'b00};
            epoch_d = ~epoch_q;
        end else if (issue_s) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end else begin
            pc_d = pc_q;
        end

        // A flush wins over any pop or push in the same cycle.
        if (redirect) begin
            count_d = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    fifo_instr_d[i] = fifo_instr_q[i+1];
                    fifo_pc_d[i]    = fifo_pc_q[i+1];
                end
                wr_idx_s = count_q - CW'(1);
            end else begin
                wr_idx_s = count_q;
            end
            if (push_s) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (wr_idx_s == CW'(i)) begin
                        fifo_instr_d[i] = imem_rdata;
                        fifo_pc_d[i]    = inflight_pc_q;
                    end else begin
                        fifo_instr_d[i] = fifo_instr_d[i];
                    end
                end
            end else begin
                fifo_pc_d = fifo_pc_d;
            end
            count_d = count_q - CW'(pop_s) + CW'(push_s);
        end
        valid_d = (count_d != {CW{1'b0}});
    end

    // State registers; reset drops buffered entries and any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            pc_q             <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= 32'h0000_0000;
            count_q          <= {CW{1'b0}};
            valid_q          <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]    <= 32'h0000_0000;
            end
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            inflight_pc_q    <= inflight_pc_d;
            count_q          <= count_d;
            valid_q          <= valid_d;
            fifo_instr_q     <= fifo_instr_d;
            fifo_pc_q        <= fifo_pc_d;
        end
    end

    instr_fetch_unit_chk #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s & ~redirect),
        .count (count_q)
    );
endmodule

// FIFO occupancy invariants for the fetch buffer.
module instr_fetch_unit_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    a_push_room: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> ((count < CW'(DEPTH)) || pop));
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected PCs are queued by the
// stimulus, and monitors compare every accepted instruction against them.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, rst_n_w;
    logic        imem_req, imem_req_w;
    logic [31:0] imem_addr, imem_addr_w;
    logic [31:0] imem_rdata, imem_rdata_w;
    logic [31:0] instr, instr_w, instr_pc, instr_pc_w;
    logic        instr_valid, instr_valid_w;
    logic        instr_ready, redirect;
    logic [31:0] redirect_target;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wrap_q[$];
    logic [31:0] hold_i, hold_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_target(redirect_target)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .instr(instr_w), .instr_pc(instr_pc_w),
        .instr_valid(instr_valid_w), .instr_ready(1'b1),
        .redirect(1'b0), .redirect_target(32'h0000_0000)
    );

    // Synchronous instruction memories: data = address ^ A5A5_0000.
    always @(posedge clk) begin
        imem_rdata   <= imem_req ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
        imem_rdata_w <= imem_req_w ? (imem_addr_w ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_acc(input int target, input string nm);
        int t = 0;
        while (acc_cnt < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 32'(acc_cnt >= target), 32'd1);
    endtask

    // Main monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr got_pc=%h expected none", instr_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e);
                chk("instr", instr, e ^ 32'hA5A5_0000);
                acc_cnt++;
            end
        end
    end

    // Wrap-instance monitor.
    always @(negedge clk) begin
        if (rst_n_w && instr_valid_w && wrap_q.size() != 0) begin
            logic [31:0] e;
            e = wrap_q.pop_front();
            chk("wrap_pc", instr_pc_w, e);
            chk("wrap_instr", instr_w, e ^ 32'hA5A5_0000);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rst_n_w = 1'b0;
        instr_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0000_0000;
        wrap_q.push_back(32'hFFFF_FFF8);
        wrap_q.push_back(32'hFFFF_FFFC);
        wrap_q.push_back(32'h0000_0000);
        wrap_q.push_back(32'h0000_0004);
        wrap_q.push_back(32'h0000_0008);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0000);
        chk("rst_pc", instr_pc, 32'h0000_0000);

        // Test 1: reset release, streaming at full rate.
        @(posedge clk); #1;
        rst_n = 1'b1; rst_n_w = 1'b1;
        push_stream(32'h0000_0000, 40);
        @(posedge clk);
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0000_0000);
        chk("c0_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("c1_addr", imem_addr, 32'h0000_0004);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_pc", instr_pc, 32'h0000_0000);

        // Test 2: six-cycle stall, outputs held, no requests once full.
        repeat (4) @(posedge clk); #1;
        instr_ready = 1'b0;
        @(negedge clk);
        hold_i = instr; hold_pc = instr_pc;
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_req0", 32'(imem_req), 32'd0);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            chk("stall_instr", instr, hold_i);
            chk("stall_pc", instr_pc, hold_pc);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_acc(acc_cnt + 6, "resume_progress");

        // Test 3: redirect to 0x103 while the buffer is full.
        @(posedge clk); #1;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        redirect = 1'b1; redirect_target = 32'h0000_0103;
        exp_q.delete();
        push_stream(32'h0000_0100, 20);
        @(negedge clk);
        chk("t3_T_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        redirect = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("t3_T1_valid", 32'(instr_valid), 32'd0);
        chk("t3_T1_req", 32'(imem_req), 32'd1);
        chk("t3_T1_addr", imem_addr, 32'h0000_0100);
        @(negedge clk);
        chk("t3_T2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("t3_T3_valid", 32'(instr_valid), 32'd1);
        chk("t3_T3_pc", instr_pc, 32'h0000_0100);
        wait_acc(acc_cnt + 5, "t3_progress");

        // Test 4: redirect coinciding with pop and response arrival.
        repeat (4) @(posedge clk); #1;
        redirect = 1'b1; redirect_target = 32'h0000_0200;
        exp_q.delete();
        push_stream(32'h0000_0200, 20);
        @(negedge clk);
        chk("t4_T_valid", 32'(instr_valid), 32'd1);
        chk("t4_T_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("t4_T1_valid", 32'(instr_valid), 32'd0);
        chk("t4_T1_addr", imem_addr, 32'h0000_0200);
        @(negedge clk);
        @(negedge clk);
        chk("t4_T3_valid", 32'(instr_valid), 32'd1);
        chk("t4_T3_pc", instr_pc, 32'h0000_0200);
        wait_acc(acc_cnt + 5, "t4_progress");

        // Test 6: asynchronous reset with two entries buffered.
        @(posedge clk); #1;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk); #2;
        chk("t6_pre_valid", 32'(instr_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(instr_valid), 32'd0);
        chk("t6_async_req", 32'(imem_req), 32'd0);
        exp_q.delete();
        push_stream(32'h0000_0000, 20);
        @(posedge clk); #1;
        rst_n = 1'b1; instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, 32'h0000_0000);
        wait_acc(acc_cnt + 4, "t6_progress");

        // Test 5 runs in parallel on the wrap instance; confirm it drained.
        chk("wrap_drained", 32'(wrap_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
